// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, fixed-priority product select,
// per-product stock, timed dispense and one-coin-at-a-time change/refund payout.
module vend_sequencer #(
    parameter int PRICE_LO        = 30,
    parameter int PRICE_HI        = 40,
    parameter int STOCK_INIT      = 30,
    parameter int DISPENSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coffee,
    input  logic       cold_drink,
    input  logic       candy,
    input  logic       snack,
    input  logic       ten_bucks,
    input  logic       twenty_bucks,
    input  logic       cancel,
    input  logic       restock,
    output logic       product,
    output logic [1:0] product_sel,
    output logic       change,
    output logic       refund,
    output logic       coin_reject,
    output logic [5:0] credit,
    output logic       busy,
    output logic [3:0] sold_out
);
    typedef enum logic [2:0] {IDLE, COLLECT, DISPENSE, CHANGE, REFUND} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DSP_LAST = DW'(DISPENSE_CYCLES - 1);
    localparam logic [5:0]    P_LO     = 6'(PRICE_LO);
    localparam logic [5:0]    P_HI     = 6'(PRICE_HI);
    localparam logic [5:0]    S_INIT   = 6'(STOCK_INIT);

    state_t          state_q, state_d;
    logic [5:0]      credit_q, credit_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0][5:0] stock_q, stock_d;
    logic [3:0]      sold_out_q, sold_out_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            ph_q, ph_d;
    logic            pend_q, pend_d;
    logic            product_q, product_d;
    logic            change_q, change_d;
    logic            refund_q, refund_d;
    logic            coin_reject_q, coin_reject_d;
    logic            busy_q, busy_d;

    logic [5:0] coin_val, price;
    logic [6:0] credit_sum;
    logic       coin_in, coin_ok, coin_acc;
    logic [3:0] req;
    logic [1:0] win;
    logic       enter_disp, leave_disp, reload;

    assign coin_val   = (ten_bucks ? 6'd10 : 6'd0) + (twenty_bucks ? 6'd20 : 6'd0);
    assign coin_in    = ten_bucks | twenty_bucks;
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok    = ((state_q == IDLE) || (state_q == COLLECT)) && (credit_sum <= 7'd60);
    assign coin_acc   = coin_in && coin_ok;
    assign price      = sel_q[1] ? P_LO : P_HI;

    // Sold-out products are masked before the fixed-priority pick
    always_comb begin
        for (int i = 0; i < 4; i++) req[i] = 1'b0;
        req[0] = coffee     && (stock_q[0] != 6'd0);
        req[1] = cold_drink && (stock_q[1] != 6'd0);
        req[2] = candy      && (stock_q[2] != 6'd0);
        req[3] = snack      && (stock_q[3] != 6'd0);
        win    = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = coin_acc ? credit_sum[5:0] : credit_q;
        sel_d      = sel_q;
        tmo_d      = tmo_q;
        dcnt_d     = dcnt_q;
        ph_d       = ph_q;
        enter_disp = 1'b0;

        case (state_q)
            IDLE: begin
                if (cancel && credit_q != 6'd0) begin
                    state_d = REFUND;
                    ph_d    = 1'b1;
                end else if (|req) begin
                    state_d = COLLECT;
                    sel_d   = win;
                    tmo_d   = '0;
                end
            end
            COLLECT: begin
                // cancel outranks a reached price
                if (cancel) begin
                    state_d = (credit_q != 6'd0) ? REFUND : IDLE;
                    ph_d    = 1'b1;
                end else if (credit_q >= price) begin
                    state_d    = DISPENSE;
                    credit_d   = credit_d - price;
                    dcnt_d     = DSP_LAST;
                    enter_disp = 1'b1;
                end else if (coin_acc) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = (credit_q != 6'd0) ? REFUND : IDLE;
                    ph_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DISPENSE: begin
                if (dcnt_q == '0) begin
                    state_d = (credit_q != 6'd0) ? CHANGE : IDLE;
                    ph_d    = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            CHANGE, REFUND: begin
                // high phase pays one coin, low phase either re-arms or exits
                if (ph_q) begin
                    credit_d = credit_q - 6'd10;
                    ph_d     = 1'b0;
                end else if (credit_q == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    ph_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // restock arriving mid-dispense waits until the motor cycle ends
        leave_disp = (state_q == DISPENSE) && (state_d != DISPENSE);
        reload     = (restock || pend_q) && ((state_q != DISPENSE) || leave_disp);
        pend_d     = (restock || pend_q) && (state_q == DISPENSE) && !leave_disp;
        stock_d    = reload ? {4{S_INIT}} : stock_q;
        if (enter_disp && stock_d[sel_q] != 6'd0) stock_d[sel_q] = stock_d[sel_q] - 6'd1;

        for (int i = 0; i < 4; i++) sold_out_d[i] = (stock_q[i] == 6'd0);

        product_d     = (state_d == DISPENSE);
        change_d      = (state_d == CHANGE) && ph_d;
        refund_d      = (state_d == REFUND) && ph_d;
        busy_d        = (state_d == DISPENSE) || (state_d == CHANGE) || (state_d == REFUND);
        coin_reject_d = coin_in && !coin_ok;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            sel_q         <= '0;
            stock_q       <= {4{S_INIT}};
            sold_out_q    <= {4{S_INIT == 6'd0}};
            tmo_q         <= '0;
            dcnt_q        <= '0;
            ph_q          <= 1'b0;
            pend_q        <= 1'b0;
            product_q     <= 1'b0;
            change_q      <= 1'b0;
            refund_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            stock_q       <= stock_d;
            sold_out_q    <= sold_out_d;
            tmo_q         <= tmo_d;
            dcnt_q        <= dcnt_d;
            ph_q          <= ph_d;
            pend_q        <= pend_d;
            product_q     <= product_d;
            change_q      <= change_d;
            refund_q      <= refund_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign product     = product_q;
    assign product_sel = sel_q;
    assign change      = change_q;
    assign refund      = refund_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
    assign sold_out    = sold_out_q;
endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the vending machine datapath. It accepts 10/20 coin pulses and four product-select inputs, arbitrates simultaneous selections, and holds the running credit. It tracks per-product stock, sequences the timed dispense, and pays out change or refunds one 10-unit coin pulse at a time. It sits between the front-panel and coin-acceptor inputs and the dispense-motor and coin-hopper outputs.

## Interface
- PRICE_LO, 30, price of candy and snack (multiple of 10, ≤ 60)
- PRICE_HI, 40, price of coffee and cold_drink (multiple of 10, ≤ 60)
- STOCK_INIT, 30, per-product stock loaded at reset/restock (≤ 63)
- DISPENSE_CYCLES, 4, cycles `product` is held high (≥ 1)
- TIMEOUT_CYCLES, 255, idle cycles in COLLECT before auto-refund (≥ 1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- coffee, cold_drink, candy, snack  in  1 each  selection requests (level, sampled each cycle)
- ten_bucks, twenty_bucks  in  1 each  coin-accepted pulses, one cycle per coin
- cancel  in  1  cancel request (sampled each cycle)
- restock  in  1  pulse: reload all stock counters to STOCK_INIT
- product  out  1  dispense motor enable
- product_sel  out  2  product being served: 0 coffee, 1 cold_drink, 2 candy, 3 snack
- change  out  1  one pulse per 10 units of change
- refund  out  1  one pulse per 10 units refunded
- coin_reject  out  1  one-cycle pulse: the coin(s) of the previous cycle were not accepted
- credit  out  6  current credit, unsigned
- busy  out  1  high in DISPENSE, CHANGE, REFUND
- sold_out  out  4  bit i high when stock of product i is 0

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE, REFUND. Reset → IDLE.
- Coins are accepted in IDLE and COLLECT only.
  - Value = 10·ten_bucks + 20·twenty_bucks; both high in one cycle = 30.
  - If credit + value > 60, or the state is DISPENSE/CHANGE/REFUND: the whole value is rejected, credit is unchanged, and coin_reject pulses.
- IDLE: on any selection of a non-sold-out product, latch it into product_sel and go to COLLECT.
  - Arbitration is fixed priority: coffee > cold_drink > candy > snack. Sold-out requests are masked before arbitration.
  - cancel with credit > 0 → REFUND. cancel with credit 0 → no effect.
- COLLECT: the selection is locked; further select inputs are ignored.
  - credit ≥ price(product_sel) → DISPENSE.
  - cancel → REFUND if credit > 0, else IDLE.
  - A timeout counter reloads on entry and on every accepted coin. At TIMEOUT_CYCLES without a coin → REFUND (credit > 0) or IDLE (credit 0).
  - When cancel and a price-reached condition occur in the same cycle, cancel wins.
- DISPENSE: on entry, decrement stock[product_sel] and subtract price from credit.
  - product is high for exactly DISPENSE_CYCLES cycles.
  - Then → CHANGE if credit > 0, else IDLE.
- CHANGE / REFUND: emit pulses on change / refund respectively, one cycle high then one cycle low per coin. credit decrements by 10 on each high cycle.
  - Exit to IDLE on the cycle after the last low cycle.
  - credit is 0 on exit; product_sel is held until IDLE.
- cancel, selections and restock are ignored while busy. Exception: restock is honoured in any state except DISPENSE, where it is held pending and applied on exit.
- Stock counters are 6-bit and never decrement below 0. DISPENSE is only reachable for stock ≥ 1.
- Credit arithmetic is 6-bit unsigned. The 60-unit cap guarantees no overflow, and change/refund counts are always integral.

## Timing
- Reset values: product 0, product_sel 0, change 0, refund 0, coin_reject 0, credit 0, busy 0. sold_out is 0 with STOCK_INIT > 0. All stock = STOCK_INIT.
- Coin pulse at cycle n → credit updated at n+1; coin_reject (if any) high at n+1 only.
- Selection at n in IDLE → COLLECT and product_sel valid at n+1.
- If credit ≥ price at n+1 → DISPENSE at n+2; product high n+2 … n+1+DISPENSE_CYCLES.
- credit shows the post-price value from the first DISPENSE cycle.
- First change/refund pulse is high in the first cycle of CHANGE/REFUND. k coins occupy 2k cycles.
- sold_out updates the cycle after the stock decrement or reload.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously). Credit is discarded and stock is reloaded.

## Test plan
- Select candy, insert 10 then 20 → credit 10, then 30. DISPENSE begins 1 cycle after credit reaches 30. product high 4 cycles, product_sel=2. No change pulse. candy stock decrements 30→29.
- Insert 20, 20, 20 → credit 60. Select coffee → product_sel=0, dispense. credit 20 after dispense, then two change pulses (4 cycles). Return to IDLE with credit 0.
- Insert 20 then cancel in IDLE → two refund pulses. No product. Stock unchanged.
- Credit 50, then pulse ten_bucks and twenty_bucks together → coin_reject high one cycle, credit stays 50. Then a single ten_bucks is accepted → credit 60.
- Raise coffee and snack in the same cycle → coffee wins. Drain snack stock to 0 (set STOCK_INIT=1) → sold_out[3]=1, and a snack-only request leaves the block in IDLE.
- Select cold_drink, insert 10, then no coins for TIMEOUT_CYCLES → one refund pulse, return to IDLE. Separately, assert reset mid-DISPENSE → product drops immediately, credit 0, stock reloaded.
